mig_parity_seq: RTL

MIG_PARITY_SEQ -- requirements
Module: mig_parity_seq

---
 rtl/mig_parity_seq_pkg.sv | 61 ++++++
 rtl/mig_parity_seq_maj3_inv.sv | 25 ++
 rtl/mig_parity_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mig_parity_seq_pkg.sv
// Shared definitions for the sequential majority-inverter-graph parity engine.
// Holds the FSM state encoding, node-index and instruction types, the
// constant-zero node index and the fixed six-gate program that evaluates
// odd parity of five inputs as two cascaded 3-input XOR structures.
package mig_parity_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int NODE_W      = 4;
    localparam int NODE_SPACE  = 2 ** NODE_W;
    localparam int ROM_STEP_W  = 3;

    typedef logic [NODE_W-1:0] node_idx_t;

    // Index 15 never maps onto a stored node, so it always reads as 0.
    localparam node_idx_t CONST0 = node_idx_t'(15);

    typedef struct packed {
        node_idx_t idx;
        logic      inv;
    } operand_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
        operand_t c;
    } instr_t;

    // Node map: 0-4 = x0..x4, 5-10 = g0..g5.
    // g0..g2 form XOR3(x0,x1,x2); g3..g5 repeat the pattern on (x3,x4,g2).
    localparam instr_t ROM_G0 = '{a: '{idx: 4'd0, inv: 1'b1}, b: '{idx: 4'd1, inv: 1'b0}, c: '{idx: 4'd2, inv: 1'b0}};
    localparam instr_t ROM_G1 = '{a: '{idx: 4'd1, inv: 1'b0}, b: '{idx: 4'd2, inv: 1'b0}, c: '{idx: 4'd5, inv: 1'b1}};
    localparam instr_t ROM_G2 = '{a: '{idx: 4'd0, inv: 1'b0}, b: '{idx: 4'd5, inv: 1'b0}, c: '{idx: 4'd6, inv: 1'b1}};
    localparam instr_t ROM_G3 = '{a: '{idx: 4'd3, inv: 1'b1}, b: '{idx: 4'd4, inv: 1'b0}, c: '{idx: 4'd7, inv: 1'b0}};
    localparam instr_t ROM_G4 = '{a: '{idx: 4'd4, inv: 1'b0}, b: '{idx: 4'd7, inv: 1'b0}, c: '{idx: 4'd8, inv: 1'b1}};
    localparam instr_t ROM_G5 = '{a: '{idx: 4'd3, inv: 1'b0}, b: '{idx: 4'd8, inv: 1'b0}, c: '{idx: 4'd9, inv: 1'b1}};

    localparam instr_t ROM_NOP = '{a: '{idx: CONST0, inv: 1'b0},
                                   b: '{idx: CONST0, inv: 1'b0},
                                   c: '{idx: CONST0, inv: 1'b0}};

    function automatic instr_t rom_entry(input logic [ROM_STEP_W-1:0] step);
        instr_t e;
        case (step)
            3'd0:    e = ROM_G0;
            3'd1:    e = ROM_G1;
            3'd2:    e = ROM_G2;
            3'd3:    e = ROM_G3;
            3'd4:    e = ROM_G4;
            3'd5:    e = ROM_G5;
            default: e = ROM_NOP;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mig_parity_seq_maj3_inv.sv
// maj3_inv: combinational 3-input majority gate with per-operand inversion.
// Ports:
//   a, b, c             - data bits
//   inv_a, inv_b, inv_c - invert the corresponding data bit before voting
//   y                   - majority of the (optionally inverted) operands
module maj3_inv (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic inv_a,
    input  logic inv_b,
    input  logic inv_c,
    output logic y
);

    logic a_eff;
    logic b_eff;
    logic c_eff;

    assign a_eff = a ^ inv_a;
    assign b_eff = b ^ inv_b;
    assign c_eff = c ^ inv_c;
    assign y     = (a_eff & b_eff) | (a_eff & c_eff) | (b_eff & c_eff);

endmodule

// File: rtl/mig_parity_seq.sv
// mig_parity_seq: evaluates odd parity of x by stepping a six-gate
// majority-inverter program through one shared maj3_inv, one gate per cycle.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - operand handshake (ready only in IDLE)
//   x[NUM_IN-1:0]        - operand bits
//   out_valid / out_ready- result handshake (valid only in DONE)
//   y                    - parity result, taken from node g5
//   busy                 - high in LOAD, EVAL and DONE
module mig_parity_seq
    import mig_parity_seq_pkg::*;
#(
    parameter int NUM_IN    = 5,
    parameter int NUM_GATES = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              y,
    output logic              busy
);

    localparam int NUM_NODES = NUM_IN + NUM_GATES;
    localparam int STEP_W    = ROM_STEP_W;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_GATES - 1);

    state_e                 state_q,    state_d;
    logic [STEP_W-1:0]      step_q,     step_d;
    logic [NUM_NODES-1:0]   nodes_q,    nodes_d;
    // Set once the last gate has been written; the following EVAL cycle
    // moves to DONE so that DONE entry lands on its own edge.
    logic                   eval_end_q, eval_end_d;

    logic [NODE_SPACE-1:0]  node_vec;
    instr_t                 instr;
    logic                   maj_out;

    // Operands come only from the registered node file; unused indices
    // (including CONST0) read as zero through the padding.
    assign node_vec = {{(NODE_SPACE - NUM_NODES){1'b0}}, nodes_q};
    assign instr    = rom_entry(step_q);

    maj3_inv u_maj (
        .a     (node_vec[instr.a.idx]),
        .b     (node_vec[instr.b.idx]),
        .c     (node_vec[instr.c.idx]),
        .inv_a (instr.a.inv),
        .inv_b (instr.b.inv),
        .inv_c (instr.c.inv),
        .y     (maj_out)
    );

    always_comb begin
        // NOTE: every combinational target gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        step_d     = step_q;
        nodes_d    = nodes_q;
        eval_end_d = eval_end_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    nodes_d[NUM_IN-1:0] = x;
                    state_d             = LOAD;
                end
            end
            LOAD: begin
                nodes_d[NUM_NODES-1:NUM_IN] = '0;
                step_d                      = '0;
                eval_end_d                  = 1'b0;
                state_d                     = EVAL;
            end
            EVAL: begin
                if (eval_end_q) begin
                    state_d = DONE;
                end else begin
                    for (int i = 0; i < NUM_GATES; i++) begin
                        if (STEP_W'(i) == step_q) begin
                            nodes_d[NUM_IN + i] = maj_out;
                        end
                    end
                    // The counter parks on the last step instead of wrapping,
                    // keeping the ROM address inside the program.
                    if (step_q == LAST_STEP) begin
                        eval_end_d = 1'b1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the node file is a handful of flops, so it is reset along with
    // the control state; an aborted evaluation leaves nothing behind on y.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            nodes_q    <= '0;
            eval_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            nodes_q    <= nodes_d;
            eval_end_q <= eval_end_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = nodes_q[NUM_NODES-1];

endmodule
